// File: rtl/mem_stream_reader_pkg.sv
// Shared types and constants for the RAM read-side stream controller.
package mem_stream_reader_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FifoCntW   = $clog2(FIFO_DEPTH + 1);

    typedef logic [1:0] state_t;
    localparam state_t StIdle  = 2'd0;
    localparam state_t StRun   = 2'd1;
    localparam state_t StDrain = 2'd2;

    // Wraps on the last real word, so non-power-of-2 depths work.
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned words);
        return (addr == words - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/mem_stream_reader_if.sv
// Control, RAM read port and output stream of the reader, bundled as one interface.
interface mem_stream_reader_if #(
    parameter int unsigned bits    = 8,
    parameter int unsigned address = 2
);
    logic               start;
    logic [address-1:0] base_addr;
    logic [address:0]   length;
    logic               busy;
    logic               done;
    logic [address-1:0] r_addr;
    logic [bits-1:0]    r_data;
    logic               m_valid;
    logic [bits-1:0]    m_data;
    logic               m_ready;

    modport master (
        input  start, base_addr, length, r_data, m_ready,
        output busy, done, r_addr, m_valid, m_data
    );

    modport slave (
        output start, base_addr, length, r_data, m_ready,
        input  busy, done, r_addr, m_valid, m_data
    );
endinterface

// File: rtl/mem_stream_reader_stream_fifo.sv
// Synchronous FIFO with a registered head word; same-cycle push and pop are both honoured.
module mem_stream_reader_stream_fifo #(
    parameter  int unsigned bits       = 8,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH),
    localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [bits-1:0] push_data,
    input  logic            pop,
    output logic [bits-1:0] head,
    output logic [CntW-1:0] count,
    output logic            empty,
    output logic            full
);
    logic [bits-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [bits-1:0] head_q;
    logic            do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
            // Head tracks the oldest entry; a push into an emptying FIFO bypasses storage.
            if (do_pop) begin
                if (count_q > CntW'(1)) begin
                    head_q <= mem_q[PtrW'(rd_ptr_q + 1'b1)];
                end else if (do_push) begin
                    head_q <= push_data;
                end
            end else if (do_push && empty) begin
                head_q <= push_data;
            end
        end
    end

    assign head  = head_q;
    assign count = count_q;
endmodule

// File: rtl/mem_stream_reader.sv
// Walks a RAM address range through a registered read port and streams the words out
// with valid/ready backpressure; reads are only issued when a FIFO slot is guaranteed.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int unsigned bits    = 8,
    parameter int unsigned words   = 4,
    parameter int unsigned address = $clog2(words)
) (
    input logic clk,
    input logic rst_n,
    mem_stream_reader_if.master bus
);
    localparam int unsigned LenW = address + 1;
    localparam int unsigned SumW = FifoCntW + 1;

    state_t             state_q, state_d;
    logic [address-1:0] addr_q, addr_d;
    logic [LenW-1:0]    remaining_q, remaining_d;
    logic [address-1:0] r_addr_q, r_addr_d;
    logic               v1_q, v2_q;
    logic               done_q, done_d;

    logic               issue;
    logic [address-1:0] issue_addr;
    logic [LenW-1:0]    issue_left;
    logic [FifoCntW-1:0] fifo_count;
    logic               fifo_empty, fifo_full;
    logic [bits-1:0]    fifo_head;
    logic [SumW-1:0]    credit_sum;
    logic               credit_ok;

    // Words already buffered plus words still in the read pipeline must fit the FIFO.
    assign credit_sum = {1'b0, fifo_count} + SumW'(v1_q) + SumW'(v2_q);
    assign credit_ok  = (credit_sum < SumW'(FIFO_DEPTH)) && !fifo_full;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        r_addr_d    = r_addr_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        issue_addr  = addr_q;
        issue_left  = remaining_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    issue_addr  = bus.base_addr;
                    issue_left  = bus.length;
                    addr_d      = bus.base_addr;
                    remaining_d = bus.length;
                    if (bus.length == '0) begin
                        state_d = StDrain;
                    end else begin
                        // Pipeline and FIFO are empty in idle, so the first read needs no credit.
                        issue   = 1'b1;
                        state_d = (bus.length == LenW'(1)) ? StDrain : StRun;
                    end
                end
            end
            StRun: begin
                if ((remaining_q != '0) && credit_ok) begin
                    issue = 1'b1;
                    if (remaining_q == LenW'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (!v1_q && !v2_q && fifo_empty) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (issue) begin
            r_addr_d    = issue_addr;
            addr_d      = address'(next_addr(32'(issue_addr), words));
            remaining_d = issue_left - LenW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            r_addr_q    <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            r_addr_q    <= r_addr_d;
            v1_q        <= issue;
            v2_q        <= v1_q;
            done_q      <= done_d;
        end
    end

    mem_stream_reader_stream_fifo #(
        .bits       (bits),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_stream_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (v2_q),
        .push_data (bus.r_data),
        .pop       (bus.m_ready),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.r_addr  = r_addr_q;
    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = fifo_head;
endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
Read-side controller for the block-RAM buffers that feed the systolic array. It drives the address of a RAM's fixed-latency registered read port. The read port takes r_addr on one edge and returns r_data on the next. The block walks a programmed address range and delivers the words as a valid/ready stream with full backpressure. The write side of the RAM is untouched; this block owns only r_addr and r_data.

Parameters:
bits, 8, data word width (must match the RAM)
words, 4, RAM depth
address, $clog2(words), RAM address width
FIFO_DEPTH, 4, output buffer depth (package constant, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a transfer; sampled only in IDLE
base_addr  in  address  first RAM address, latched on start
length  in  address+1  number of words to read, 0..words, latched on start
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when a transfer fully completes
r_addr  out  address  RAM read address
r_data  in  bits  RAM read data, valid one edge after r_addr is sampled
m_valid  out  1  stream data valid
m_data  out  bits  stream data
m_ready  in  1  downstream accept; a beat transfers when m_valid && m_ready

Behaviour:
- Reset is synchronous on rst_n=0 at a rising edge. busy=0, done=0, m_valid=0, r_addr=0, m_data=0. FIFO is emptied, read pipeline cleared, state=IDLE. Reset mid-transfer drops all pending data; no done pulse is generated.
- States:
  - IDLE: start=1 latches base_addr and remaining=length. If length=0, go to DRAIN; done pulses on the following edge and nothing is read. Otherwise go to RUN.
  - RUN: issue reads while remaining>0. Go to DRAIN on the edge that issues the last read.
  - DRAIN: wait until the read pipeline is empty and the FIFO is empty (last beat accepted). Then return to IDLE with done=1 for exactly one cycle.
- start is ignored outside IDLE. busy=1 in RUN and DRAIN.
- Issue rule: in RUN, at each edge, issue when remaining>0 and fifo_count + outstanding < FIFO_DEPTH. fifo_count excludes any pop in that cycle.
  - Issuing loads r_addr with the current address, sets pipeline stage v1, and decrements remaining.
  - v1 advances to v2 on the next edge. At the edge after that, r_data is written into the FIFO.
  - outstanding = v1 + v2, so it is at most 2.
- r_addr holds its value when not issuing.
- Address increment: next = (addr == words-1) ? 0 : addr+1. Wrap works for non-power-of-2 depths and for base_addr + length > words.
- Latency: with start sampled at edge E0 and m_ready=1, r_addr=base_addr after E0, and the first m_valid is high after E2. Throughput is then one beat per cycle with no bubbles.
- Backpressure: with m_ready=0, m_valid and m_data hold stable until accepted. No read is ever issued that lacks a guaranteed FIFO slot, so data is never lost or overwritten.
- FIFO write and pop in the same cycle are both honoured; the count is unchanged.
- m_data comes from the FIFO head. Beats appear in address order.

Decomposition:
- Package mem_stream_reader_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - FIFO_DEPTH=4 and its count width
  - next-address wrap function
- One sub-module, stream_fifo: synchronous FIFO, parameters bits and FIFO_DEPTH. It has push/pop/data/count/empty/full signals, the same clk and rst_n, and a registered head output.
- Top level holds the FSM, counters, the issue/credit logic and the v1/v2 pipeline.

Test Plan:
- RAM words=4 preloaded {A0,B1,C2,D3}; start base=0 length=4, m_ready=1 -> r_addr 0,1,2,3 on consecutive cycles; m_data A0,B1,C2,D3 on 4 consecutive cycles, first valid 2 edges after the start edge; done pulses once, then busy=0.
- base=3 length=3 -> r_addr 3,0,1; stream D3,A0,B1 (wrap).
- words=6, base=4 length=4 -> addresses 4,5,0,1 (non-power-of-2 wrap).
- length=4 with m_ready=0 for 10 cycles, then 1 -> at most 4 reads issued before stall; m_data=A0 held stable throughout; then all 4 beats in order, no loss or duplication.
- m_ready toggling 1,0,1,0 -> every beat delivered exactly once in order; done only after the last handshake.
- length=0 -> no read issued, m_valid stays 0, done pulses once. Assert rst_n=0 mid-RUN -> next cycle busy=0, m_valid=0, r_addr=0, no done; a new start then behaves as in the first scenario.
